// File: rtl/decode_pkg.sv
// Shared opcode map, immediate-mode encodings and decoded bundle for the ID stage.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] IMM_SEXT = 2'd0;
    localparam logic [1:0] IMM_ZEXT = 2'd1;
    localparam logic [1:0] IMM_LUI  = 2'd2;
    localparam logic [1:0] IMM_NONE = 2'd3;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    // XLEN-independent part of a decoded instruction
    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
        logic [1:0] imm_kind;
        logic [4:0] dest_reg;
        logic       reg_write;
        logic       is_rtype;
        logic       is_branch;
        logic       is_jump;
        logic       is_illegal;
    } dec_ctl_t;

    // Bundle value held in empty registers: everything zero, no immediate
    function automatic dec_ctl_t ctl_reset();
        dec_ctl_t c;
        c          = '0;
        c.imm_kind = IMM_NONE;
        return c;
    endfunction

endpackage

// File: rtl/id_decode_fields.sv
// Combinational MIPS field split, immediate extension and target computation.
module id_decode_fields
    import decode_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned LUI_SHIFT = 16
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output dec_ctl_t        ctl,
    output logic [XLEN-1:0] imm_ext,
    output logic [XLEN-1:0] br_target,
    output logic [XLEN-1:0] j_target
);

    logic [15:0]     imm16;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] pc_plus4;

    assign imm16    = instr[15:0];
    assign imm_sext = {{(XLEN-16){imm16[15]}}, imm16};
    assign pc_plus4 = pc + XLEN'(4);

    // Targets wrap modulo 2^XLEN; jump keeps the upper region bits of pc+4
    assign br_target = pc_plus4 + {imm_sext[XLEN-3:0], 2'b00};
    assign j_target  = {pc_plus4[XLEN-1:28], instr[25:0], 2'b00};

    // Opcode classification; illegal opcodes clear every class flag
    always_comb begin
        ctl            = '0;
        ctl.opcode     = instr[31:26];
        ctl.rs         = instr[25:21];
        ctl.rt         = instr[20:16];
        ctl.rd         = instr[15:11];
        ctl.shamt      = instr[10:6];
        ctl.funct      = instr[5:0];
        ctl.imm_kind   = IMM_NONE;
        ctl.dest_reg   = instr[20:16];
        ctl.reg_write  = 1'b1;
        case (instr[31:26])
            OP_RTYPE: begin
                ctl.is_rtype = 1'b1;
                ctl.dest_reg = instr[15:11];
            end
            OP_J: begin
                ctl.is_jump   = 1'b1;
                ctl.reg_write = 1'b0;
            end
            OP_JAL: begin
                ctl.is_jump  = 1'b1;
                ctl.dest_reg = REG_RA;
            end
            OP_BEQ, OP_BNE: begin
                ctl.is_branch = 1'b1;
                ctl.imm_kind  = IMM_SEXT;
                ctl.reg_write = 1'b0;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_LW: ctl.imm_kind = IMM_SEXT;
            OP_SW: begin
                ctl.imm_kind  = IMM_SEXT;
                ctl.reg_write = 1'b0;
            end
            OP_ANDI, OP_ORI, OP_XORI: ctl.imm_kind = IMM_ZEXT;
            OP_LUI:                   ctl.imm_kind = IMM_LUI;
            default: begin
                ctl.is_illegal = 1'b1;
                ctl.reg_write  = 1'b0;
            end
        endcase
    end

    // Immediate extension selected by the decoded mode
    always_comb begin
        imm_ext = '0;
        case (ctl.imm_kind)
            IMM_SEXT: imm_ext = imm_sext;
            IMM_ZEXT: imm_ext = XLEN'(imm16);
            IMM_LUI:  imm_ext = XLEN'(imm16) << LUI_SHIFT;
            default:  imm_ext = '0;
        endcase
    end

endmodule

// File: rtl/id_decode_stage.sv
// Registered decode stage with a one-entry skid buffer and synchronous flush.
module id_decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned LUI_SHIFT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      opcode,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [5:0]      funct,
    output logic [XLEN-1:0] imm_ext,
    output logic [1:0]      imm_kind,
    output logic [XLEN-1:0] br_target,
    output logic [XLEN-1:0] j_target,
    output logic [4:0]      dest_reg,
    output logic            reg_write,
    output logic            is_rtype,
    output logic            is_branch,
    output logic            is_jump,
    output logic            is_illegal
);

    dec_ctl_t        dec_ctl;
    logic [XLEN-1:0] dec_imm, dec_br, dec_j;

    state_e          state_q;
    logic            out_valid_q, in_ready_q;
    dec_ctl_t        out_ctl_q, skid_ctl_q;
    logic [XLEN-1:0] out_imm_q, out_br_q, out_j_q;
    logic [XLEN-1:0] skid_imm_q, skid_br_q, skid_j_q;

    logic accept, drain;

    id_decode_fields #(
        .XLEN      (XLEN),
        .LUI_SHIFT (LUI_SHIFT)
    ) u_fields (
        .instr     (in_instr),
        .pc        (in_pc),
        .ctl       (dec_ctl),
        .imm_ext   (dec_imm),
        .br_target (dec_br),
        .j_target  (dec_j)
    );

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    // Handshake state, output register and skid register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_ctl_q   <= ctl_reset();
            out_imm_q   <= '0;
            out_br_q    <= '0;
            out_j_q     <= '0;
            skid_ctl_q  <= ctl_reset();
            skid_imm_q  <= '0;
            skid_br_q   <= '0;
            skid_j_q    <= '0;
        end else if (flush) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        out_ctl_q   <= dec_ctl;
                        out_imm_q   <= dec_imm;
                        out_br_q    <= dec_br;
                        out_j_q     <= dec_j;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && drain) begin
                        out_ctl_q <= dec_ctl;
                        out_imm_q <= dec_imm;
                        out_br_q  <= dec_br;
                        out_j_q   <= dec_j;
                    end else if (accept) begin
                        skid_ctl_q <= dec_ctl;
                        skid_imm_q <= dec_imm;
                        skid_br_q  <= dec_br;
                        skid_j_q   <= dec_j;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_SKID;
                    end else if (drain) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (drain) begin
                        out_ctl_q  <= skid_ctl_q;
                        out_imm_q  <= skid_imm_q;
                        out_br_q   <= skid_br_q;
                        out_j_q    <= skid_j_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ST_FULL;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign opcode     = out_ctl_q.opcode;
    assign rs         = out_ctl_q.rs;
    assign rt         = out_ctl_q.rt;
    assign rd         = out_ctl_q.rd;
    assign shamt      = out_ctl_q.shamt;
    assign funct      = out_ctl_q.funct;
    assign imm_ext    = out_imm_q;
    assign imm_kind   = out_ctl_q.imm_kind;
    assign br_target  = out_br_q;
    assign j_target   = out_j_q;
    assign dest_reg   = out_ctl_q.dest_reg;
    assign reg_write  = out_ctl_q.reg_write;
    assign is_rtype   = out_ctl_q.is_rtype;
    assign is_branch  = out_ctl_q.is_branch;
    assign is_jump    = out_ctl_q.is_jump;
    assign is_illegal = out_ctl_q.is_illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: decode vectors, backpressure, flush, reset.
module tb_id_decode_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt, dest_reg;
    logic [31:0] imm_ext, br_target, j_target;
    logic [1:0]  imm_kind;
    logic        reg_write, is_rtype, is_branch, is_jump, is_illegal;

    int n_checks = 0;
    int n_errors = 0;

    logic       log_en = 1'b0;
    logic [4:0] drained[$];

    always #5 clk = ~clk;

    id_decode_stage #(.XLEN(32), .LUI_SHIFT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .funct      (funct),
        .imm_ext    (imm_ext),
        .imm_kind   (imm_kind),
        .br_target  (br_target),
        .j_target   (j_target),
        .dest_reg   (dest_reg),
        .reg_write  (reg_write),
        .is_rtype   (is_rtype),
        .is_branch  (is_branch),
        .is_jump    (is_jump),
        .is_illegal (is_illegal)
    );

    // Record rd of every instruction that leaves the stage
    always @(posedge clk) begin
        if (log_en && out_valid && out_ready) drained.push_back(rd);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_instr = 32'h2128FFFC; in_pc = 32'h0040_0000;
        tick(); tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_imm_kind",  64'(imm_kind),  64'd3);
        check("rst_imm_ext",   64'(imm_ext),   64'd0);
        check("rst_rs",        64'(rs),        64'd0);
        check("rst_dest",      64'(dest_reg),  64'd0);
        check("rst_reg_write", 64'(reg_write), 64'd0);
        in_valid = 1'b0;
        reset = 1'b0;
        tick();
        check("idle_out_valid", 64'(out_valid), 64'd0);

        // addi $8,$9,-4
        send(32'h2128FFFC, 32'h0040_0000);
        check("addi_valid", 64'(out_valid), 64'd1);
        check("addi_rs",    64'(rs),        64'd9);
        check("addi_rt",    64'(rt),        64'd8);
        check("addi_imm",   64'(imm_ext),   64'hFFFF_FFFC);
        check("addi_kind",  64'(imm_kind),  64'd0);
        check("addi_dest",  64'(dest_reg),  64'd8);
        check("addi_rw",    64'(reg_write), 64'd1);

        // ori, lui back-to-back (throughput 1/cycle)
        send(32'h35088000, 32'h0040_0004);
        check("ori_valid", 64'(out_valid), 64'd1);
        check("ori_imm",   64'(imm_ext),   64'h0000_8000);
        check("ori_kind",  64'(imm_kind),  64'd1);
        send(32'h3C081234, 32'h0040_0008);
        check("lui_imm",   64'(imm_ext),   64'h1234_0000);
        check("lui_kind",  64'(imm_kind),  64'd2);
        check("lui_rw",    64'(reg_write), 64'd1);

        // beq self-loop
        send(32'h1000FFFF, 32'h0040_0010);
        check("beq_target", 64'(br_target), 64'h0040_0010);
        check("beq_branch", 64'(is_branch), 64'd1);
        check("beq_rw",     64'(reg_write), 64'd0);
        check("beq_kind",   64'(imm_kind),  64'd0);

        // jal
        send(32'h0C100000, 32'h0040_0020);
        check("jal_target", 64'(j_target),  64'h0040_0000);
        check("jal_dest",   64'(dest_reg),  64'd31);
        check("jal_jump",   64'(is_jump),   64'd1);
        check("jal_rw",     64'(reg_write), 64'd1);
        check("jal_kind",   64'(imm_kind),  64'd3);

        // R-type: rs=1 rt=2 rd=3 shamt=4 funct=0x20
        send(32'h00221920, 32'h0040_0024);
        check("r_rtype", 64'(is_rtype), 64'd1);
        check("r_dest",  64'(dest_reg), 64'd3);
        check("r_shamt", 64'(shamt),    64'd4);
        check("r_funct", 64'(funct),    64'h20);
        check("r_imm",   64'(imm_ext),  64'd0);

        // Branch target wraps past 2^32
        send(32'h10000001, 32'hFFFF_FFFC);
        check("wrap_target", 64'(br_target), 64'h0000_0004);

        // sw: sign-extended, no write
        send(32'hAC08FFF0, 32'h0040_0028);
        check("sw_rw",  64'(reg_write), 64'd0);
        check("sw_imm", 64'(imm_ext),   64'hFFFF_FFF0);

        // Illegal opcode 0x3F
        send(32'hFC000000, 32'h0040_002C);
        check("ill_flag",   64'(is_illegal), 64'd1);
        check("ill_rw",     64'(reg_write),  64'd0);
        check("ill_flags0", 64'({is_rtype, is_branch, is_jump}), 64'd0);
        check("ill_kind",   64'(imm_kind),   64'd3);
        tick();
        check("drain_empty", 64'(out_valid), 64'd0);

        // Backpressure: A, B, C with out_ready low
        out_ready = 1'b0;
        drained.delete();
        log_en = 1'b1;
        in_valid = 1'b1; in_instr = 32'h00000820; in_pc = 32'h100;
        tick();
        check("bp_a_valid", 64'(out_valid), 64'd1);
        check("bp_a_rd",    64'(rd),        64'd1);
        check("bp_a_ready", 64'(in_ready),  64'd1);
        in_instr = 32'h00001020; in_pc = 32'h104;
        tick();
        check("bp_b_hold_rd", 64'(rd),       64'd1);
        check("bp_skid_rdy",  64'(in_ready), 64'd0);
        in_instr = 32'h00001820; in_pc = 32'h108;
        tick();
        check("bp_c_hold_rd", 64'(rd),        64'd1);
        check("bp_c_rdy",     64'(in_ready),  64'd0);
        check("bp_c_valid",   64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick();
        check("bp_out_b",   64'(rd),       64'd2);
        check("bp_rdy_up",  64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp_out_c",   64'(rd),        64'd3);
        check("bp_c_valid2", 64'(out_valid), 64'd1);
        tick();
        check("bp_empty",   64'(out_valid), 64'd0);
        check("bp_count",   64'(drained.size()), 64'd3);
        for (int i = 0; i < drained.size() && i < 3; i++)
            check($sformatf("bp_order%0d", i), 64'(drained[i]), 64'(i + 1));

        // Flush while in SKID with an instruction offered
        drained.delete();
        out_ready = 1'b0;
        send(32'h00000820, 32'h200);
        send(32'h00001020, 32'h204);
        check("fl_pre_rdy", 64'(in_ready), 64'd0);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00002020; in_pc = 32'h208;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready),  64'd1);
        out_ready = 1'b1;
        tick(); tick();
        check("fl_still_empty", 64'(out_valid), 64'd0);
        check("fl_no_drain",    64'(drained.size()), 64'd0);
        log_en = 1'b0;

        // Reset mid-stream
        out_ready = 1'b0;
        send(32'h2128FFFC, 32'h300);
        send(32'h35088000, 32'h304);
        reset = 1'b1; in_valid = 1'b1; in_instr = 32'h3C081234;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_ready", 64'(in_ready),  64'd1);
        check("mr_imm",   64'(imm_ext),   64'd0);
        check("mr_rs",    64'(rs),        64'd0);
        check("mr_rt",    64'(rt),        64'd0);
        check("mr_kind",  64'(imm_kind),  64'd3);
        check("mr_flags", 64'({reg_write, is_rtype, is_branch, is_jump, is_illegal}), 64'd0);
        out_ready = 1'b1;
        tick();
        check("mr_after", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
